// File: rtl/frame_buffer_writer.sv
// Packs SPI byte pairs (HI then LO) into 16-bit pixels and writes them to a frame buffer.
// Define FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN for ping-pong banks; otherwise both bank outputs are 0.
module frame_buffer_writer #(
  parameter int unsigned pixel_count = 38400,
  parameter int unsigned addr_width  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [addr_width-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  localparam logic [addr_width-1:0] LAST_PIX = addr_width'(pixel_count - 1);

  logic [1:0]            r_state;
  logic                  r_phase_lo;
  logic [7:0]            r_hi;
  logic [addr_width-1:0] r_cnt;
  logic [addr_width-1:0] r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_wr_en;
  logic                  r_frame_done;
  logic                  r_overflow;

  logic w_fill_byte;
  logic w_last_pix;

  assign w_fill_byte = (r_state == FILL) && in_valid;
  assign w_last_pix  = (r_cnt == LAST_PIX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_phase_lo   <= 1'b0;
      r_hi         <= '0;
      r_cnt        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (frame_start) begin
        // Restart wins; a byte arriving with it becomes the HI byte of pixel 0.
        r_state    <= FILL;
        r_cnt      <= '0;
        r_overflow <= 1'b0;
        r_phase_lo <= in_valid;
        if (in_valid) begin
          r_hi <= in_data;
        end
      end else if (w_fill_byte) begin
        if (!r_phase_lo) begin
          r_hi       <= in_data;
          r_phase_lo <= 1'b1;
        end else begin
          r_phase_lo <= 1'b0;
          r_wr_en    <= 1'b1;
          r_wr_data  <= {r_hi, in_data};
          r_wr_addr  <= r_cnt;
          r_cnt      <= r_cnt + 1'b1;
          if (w_last_pix) begin
            r_frame_done <= 1'b1;
            r_state      <= FULL;
          end
        end
      end else if ((r_state == FULL) && in_valid) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_en      = r_wr_en;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state == FILL);

`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
  logic r_wr_bank;

  // Swap at the edge that ends the frame_done cycle, independent of a coincident restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
    end else if (r_frame_done) begin
      r_wr_bank <= ~r_wr_bank;
    end
  end

  assign wr_bank = r_wr_bank;
  assign rd_bank = ~r_wr_bank;
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: directed scenarios plus randomized traffic
// compared every cycle against a byte-queue reference model.
module tb_frame_buffer_writer;

  localparam int PC = 4;
  localparam int AW = 3;
`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en, wr_bank, rd_bank, frame_done, busy, overflow;

  always #5 clock = ~clock;

  frame_buffer_writer #(.pixel_count(PC), .addr_width(AW)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .in_data(in_data),
    .in_valid(in_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_done(frame_done), .busy(busy),
    .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a frame is a sequence of received bytes; every second byte emits a pixel.
  bit            armed = 1'b0;
  bit            m_open = 1'b0;
  bit            m_full = 1'b0;
  int            m_pix = 0;
  byte unsigned  m_q[$];
  bit            m_bank = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [15:0]   e_data = '0;
  bit            e_en = 1'b0, e_done = 1'b0, e_ovf = 1'b0;

  always @(posedge clock) begin
    bit was_done;
    was_done = e_done;
    if (reset) begin
      armed = 1'b1; m_open = 1'b0; m_full = 1'b0; m_pix = 0; m_q.delete(); m_bank = 1'b0;
      e_addr = '0; e_data = '0; e_en = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
    end else if (armed) begin
      e_en = 1'b0;
      e_done = 1'b0;
      if (was_done) m_bank = ~m_bank;
      if (frame_start) begin
        m_open = 1'b1; m_full = 1'b0; m_pix = 0; m_q.delete(); e_ovf = 1'b0;
        if (in_valid) m_q.push_back(in_data);
      end else if (m_open && in_valid) begin
        m_q.push_back(in_data);
        if (m_q.size() == 2) begin
          e_en   = 1'b1;
          e_data = {m_q[0], m_q[1]};
          e_addr = AW'(m_pix);
          m_pix++;
          m_q.delete();
          if (m_pix == PC) begin
            e_done = 1'b1; m_open = 1'b0; m_full = 1'b1;
          end
        end
      end else if (m_full && in_valid) begin
        e_ovf = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("wr_en", wr_en, e_en);
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
      chk("frame_done", frame_done, e_done);
      chk("busy", busy, m_open);
      chk("overflow", overflow, e_ovf);
      chk("wr_bank", wr_bank, DBL ? m_bank : 1'b0);
      chk("rd_bank", rd_bank, DBL ? ~m_bank : 1'b0);
    end
  end

  // Log of DUT writes, checked against hand-computed literals in the directed part.
  int lg_addr[$];
  int lg_data[$];
  int lg_done[$];

  always @(negedge clock) begin
    if (armed) begin
      if (wr_en) begin
        lg_addr.push_back(int'(wr_addr));
        lg_data.push_back(int'(wr_data));
      end
      if (frame_done) lg_done.push_back(int'(wr_addr));
    end
  end

  task automatic clear_log();
    lg_addr.delete(); lg_data.delete(); lg_done.delete();
  endtask

  task automatic cyc(input bit fs, input bit iv, input logic [7:0] d);
    frame_start = fs; in_valid = iv; in_data = d;
    @(posedge clock); #1;
    frame_start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  function automatic int log_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_en"}, wr_en, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_wrb"}, wr_bank, 0);
    chk({tag, "_rdb"}, rd_bank, DBL);
  endtask

  task automatic finish_frame(input int nbytes);
    for (int i = 0; i < nbytes; i++) send(8'($urandom));
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int exp1[4];
    exp1 = '{32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_reset_vals("rst");

    // Complete frame of four pixels.
    clear_log();
    cyc(1'b1, 1'b0, 8'h00);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("f1_nwr", lg_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f1_addr%0d", i), log_at(lg_addr, i), i);
      chk($sformatf("f1_data%0d", i), log_at(lg_data, i), exp1[i]);
    end
    chk("f1_ndone", lg_done.size(), 1);
    chk("f1_done_addr", log_at(lg_done, 0), 3);
    chk("f1_busy", busy, 0);
    chk("f1_wrb", wr_bank, DBL);
    chk("f1_rdb", rd_bank, 0);

    // Byte after a completed frame is an overflow; restart clears it.
    clear_log();
    send(8'hAA);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovf_set", overflow, 1);
    chk("ovf_nwr", lg_addr.size(), 0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("ovf_clr", overflow, 0);
    chk("ovf_busy", busy, 1);

    // Restart mid-frame abandons the pending HI byte.
    clear_log();
    send(8'h11); send(8'h22); send(8'h33);
    cyc(1'b1, 1'b0, 8'h00);
    send(8'h44); send(8'h55);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ab_nwr", lg_addr.size(), 2);
    chk("ab_data0", log_at(lg_data, 0), 32'h1122);
    chk("ab_addr1", log_at(lg_addr, 1), 0);
    chk("ab_data1", log_at(lg_data, 1), 32'h4455);
    chk("ab_ndone", lg_done.size(), 0);
    finish_frame(6);
    chk("f2_ndone", lg_done.size(), 1);
    chk("f2_wrb", wr_bank, 0);
    chk("f2_rdb", rd_bank, DBL);

    // Restart with a byte in the same cycle.
    clear_log();
    cyc(1'b1, 1'b1, 8'h77);
    send(8'h88);
    cyc(1'b0, 1'b0, 8'h00);
    chk("sc_nwr", lg_addr.size(), 1);
    chk("sc_addr", log_at(lg_addr, 0), 0);
    chk("sc_data", log_at(lg_data, 0), 32'h7788);
    finish_frame(6);
    chk("f3_wrb", wr_bank, DBL);

    // Reset mid-frame, then bytes without a new frame_start.
    clear_log();
    cyc(1'b1, 1'b0, 8'h00);
    send(8'h01); send(8'h02); send(8'h03);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    chk_reset_vals("mid_rst");
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
    cyc(1'b0, 1'b0, 8'h00);
    chk("mid_ovf", overflow, 0);
    chk("mid_nwr", lg_addr.size(), 1);
    chk("mid_ndone", lg_done.size(), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
